// File: rtl/vector_issue_scheduler_if.sv
// Bundle of requester, VFU and response signals around the vector issue scheduler.
// slave = the scheduler itself, master = the requesters, VFU and response consumer.
interface vector_issue_scheduler_if #(
    parameter int NUM_REQ          = 2,
    parameter int REQ_INDEX_SIZE   = 1,
    parameter int PAYLOAD_WIDTH    = 48,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int RESULT_WIDTH     = 256
);
    logic [NUM_REQ-1:0]                      req;
    logic [NUM_REQ*PAYLOAD_WIDTH-1:0]        req_payload;
    logic [NUM_REQ*(ENTRY_INDEX_SIZE+1)-1:0] req_length;
    logic [NUM_REQ-1:0]                      grant;

    logic                                    vfu_execute;
    logic [PAYLOAD_WIDTH-1:0]                vfu_payload;
    logic [ENTRY_INDEX_SIZE:0]               vfu_length;
    logic [1:0]                              vfu_status;
    logic [RESULT_WIDTH-1:0]                 vfu_result;
    logic                                    vfu_is_mask;

    logic                                    done;
    logic [REQ_INDEX_SIZE-1:0]               done_id;
    logic [RESULT_WIDTH-1:0]                 done_result;
    logic                                    done_is_mask;
    logic                                    done_err;
    logic                                    done_ack;

    logic                                    busy;
    logic                                    timeout_err;

    modport slave (
        input  req, req_payload, req_length,
        input  vfu_status, vfu_result, vfu_is_mask,
        input  done_ack,
        output grant, vfu_execute, vfu_payload, vfu_length,
        output done, done_id, done_result, done_is_mask, done_err,
        output busy, timeout_err
    );

    modport master (
        output req, req_payload, req_length,
        output vfu_status, vfu_result, vfu_is_mask,
        output done_ack,
        input  grant, vfu_execute, vfu_payload, vfu_length,
        input  done, done_id, done_result, done_is_mask, done_err,
        input  busy, timeout_err
    );
endinterface

// File: rtl/vector_issue_scheduler.sv
// Round-robin issue of one vector op at a time to a shared VFU; req->done is 3 cycles + VFU time.
// rdy_in low freezes all state; the held done is released only by done_ack with rdy_in high.
module vector_issue_scheduler #(
    parameter int NUM_REQ          = 2,
    parameter int REQ_INDEX_SIZE   = 1,
    parameter int PAYLOAD_WIDTH    = 48,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int RESULT_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    vector_issue_scheduler_if.slave bus
);
    localparam int LEN_W = ENTRY_INDEX_SIZE + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [1:0] VFU_FINISHED = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [REQ_INDEX_SIZE-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic                      done_q, done_d;
    logic [REQ_INDEX_SIZE-1:0] id_q, id_d;
    logic [PAYLOAD_WIDTH-1:0]  payload_q, payload_d;
    logic [LEN_W-1:0]          length_q, length_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic                      is_mask_q, is_mask_d;
    logic                      err_q, err_d;
    logic                      timeout_err_q, timeout_err_d;

    logic                      win_vld;
    logic [REQ_INDEX_SIZE-1:0] win_idx;
    logic [REQ_INDEX_SIZE-1:0] cand;
    logic [PAYLOAD_WIDTH-1:0]  win_payload;
    logic [LEN_W-1:0]          win_length;

    // Scan from the farthest offset down so the candidate nearest rr_ptr overwrites the rest.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = REQ_INDEX_SIZE'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_payload = bus.req_payload[int'(win_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign win_length  = bus.req_length[int'(win_idx)*LEN_W +: LEN_W];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        grant_d       = grant_q;
        done_d        = done_q;
        id_d          = id_q;
        payload_d     = payload_q;
        length_d      = length_q;
        result_d      = result_q;
        is_mask_d     = is_mask_q;
        err_d         = err_q;
        timeout_err_d = timeout_err_q;

        if (rdy_in) begin
            grant_d = '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        id_d      = win_idx;
                        payload_d = win_payload;
                        length_d  = win_length;
                        grant_d   = NUM_REQ'(1) << win_idx;
                        if (win_length != '0) begin
                            state_d = ISSUE;
                        end else begin
                            // Zero-length work never reaches the VFU; answer with an empty result.
                            state_d   = RESP;
                            done_d    = 1'b1;
                            result_d  = '0;
                            is_mask_d = 1'b0;
                            err_d     = 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
                WAIT: begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (bus.vfu_status == VFU_FINISHED) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        result_d  = bus.vfu_result;
                        is_mask_d = bus.vfu_is_mask;
                        err_d     = 1'b0;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d       = RESP;
                        done_d        = 1'b1;
                        result_d      = '0;
                        is_mask_d     = 1'b0;
                        err_d         = 1'b1;
                        timeout_err_d = 1'b1;
                    end
                end
                RESP: begin
                    if (bus.done_ack) begin
                        state_d  = IDLE;
                        done_d   = 1'b0;
                        rr_ptr_d = (id_q == REQ_INDEX_SIZE'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            grant_q       <= '0;
            done_q        <= 1'b0;
            id_q          <= '0;
            payload_q     <= '0;
            length_q      <= '0;
            result_q      <= '0;
            is_mask_q     <= 1'b0;
            err_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            id_q          <= id_d;
            payload_q     <= payload_d;
            length_q      <= length_d;
            result_q      <= result_d;
            is_mask_q     <= is_mask_d;
            err_q         <= err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.vfu_execute  = (state_q == ISSUE) && rdy_in;
    assign bus.vfu_payload  = payload_q;
    assign bus.vfu_length   = length_q;
    assign bus.done         = done_q;
    assign bus.done_id      = id_q;
    assign bus.done_result  = result_q;
    assign bus.done_is_mask = is_mask_q;
    assign bus.done_err     = err_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Directed bench for vector_issue_scheduler with a small reactive VFU model.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_vector_issue_scheduler;
    localparam logic [255:0] RES_PAT = {32{8'hA5}};
    localparam logic [47:0]  PAY0    = 48'h1234_5678_9ABC;
    localparam logic [47:0]  PAY1    = 48'hCAFE_0000_BEEF;

    logic clk;
    logic rst;
    logic rdy_in;

    vector_issue_scheduler_if bus ();

    vector_issue_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // VFU model: after an execute it reports WORKING for work_cycles cycles, then one FINISHED
    // cycle; a negative work_cycles keeps it WORKING forever.
    int work_cycles = 2;
    int rem         = 0;
    int exec_cnt    = 0;
    int overlap     = 0;
    bit in_flight   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            in_flight = 1'b0;
            bus.vfu_status <= 2'b00;
        end else begin
            if (bus.done) in_flight = 1'b0;
            if (bus.vfu_execute) begin
                if (in_flight) overlap++;
                in_flight = 1'b1;
                exec_cnt++;
                rem = work_cycles;
                bus.vfu_status <= (work_cycles == 0) ? 2'b10 : 2'b01;
            end else if (bus.vfu_status == 2'b01) begin
                if (work_cycles >= 0) begin
                    if (rem == 1) bus.vfu_status <= 2'b10;
                    rem--;
                end
            end else if (bus.vfu_status == 2'b10) begin
                bus.vfu_status <= 2'b00;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_grant(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.grant !== '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", bus.grant); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b want=0", bus.timeout_err); end
        total++; if (bus.vfu_length !== 4'd0) begin bad++; $display("FAIL reset_len got=%0d want=0", bus.vfu_length); end
        total++; if (bus.vfu_execute !== 1'b0) begin bad++; $display("FAIL reset_exec got=%b want=0", bus.vfu_execute); end
    endtask

    task automatic test_single();
        int lat;
        int e0;
        e0 = exec_cnt;
        work_cycles = 2;
        bus.req_length = {4'd0, 4'd4};
        bus.req = 2'b01;
        tick();
        total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", bus.grant); end
        total++; if (bus.vfu_execute !== 1'b1) begin bad++; $display("FAIL single_exec got=%b want=1", bus.vfu_execute); end
        total++; if (bus.vfu_length !== 4'd4) begin bad++; $display("FAIL single_len got=%0d want=4", bus.vfu_length); end
        total++; if (bus.vfu_payload !== PAY0) begin bad++; $display("FAIL single_pay got=%h want=%h", bus.vfu_payload, PAY0); end
        bus.req = 2'b00;
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL single_latency got=%0d want=4", lat); end
        total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL single_grant_drop got=%b want=00", bus.grant); end
        total++; if (bus.done_id !== 1'b0) begin bad++; $display("FAIL single_id got=%0d want=0", bus.done_id); end
        total++; if (bus.done_result !== RES_PAT) begin bad++; $display("FAIL single_result got=%h want=%h", bus.done_result, RES_PAT); end
        total++; if (bus.done_is_mask !== 1'b1) begin bad++; $display("FAIL single_mask got=%b want=1", bus.done_is_mask); end
        total++; if (bus.done_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", bus.done_err); end
        tick(); tick(); tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL single_done_held got=%b want=1", bus.done); end
        total++; if (exec_cnt - e0 !== 1) begin bad++; $display("FAIL single_exec_count got=%0d want=1", exec_cnt - e0); end
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_drop got=%b want=0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int lat;
        int e0;
        logic [1:0] want_g;
        do_reset();
        e0 = exec_cnt;
        overlap = 0;
        work_cycles = 1;
        bus.req_length = {4'd2, 4'd2};
        bus.req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            want_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(cyc);
            total++; if (bus.grant !== want_g) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b wait=%0d", n, bus.grant, want_g, cyc); end
            wait_done(lat);
            total++; if (lat < 0 || bus.done_id !== 1'(n % 2)) begin bad++; $display("FAIL rr_id%0d got=%0d want=%0d lat=%0d", n, bus.done_id, n % 2, lat); end
            bus.done_ack = 1'b1;
            tick();
            bus.done_ack = 1'b0;
        end
        bus.req = 2'b00;
        total++; if (overlap !== 0) begin bad++; $display("FAIL rr_overlap got=%0d want=0", overlap); end
        total++; if (exec_cnt - e0 !== 4) begin bad++; $display("FAIL rr_exec_count got=%0d want=4", exec_cnt - e0); end
    endtask

    task automatic test_zero_length();
        int e0;
        e0 = exec_cnt;
        bus.req_length = {4'd0, 4'd2};
        bus.req = 2'b10;
        tick();
        total++; if (bus.grant !== 2'b10) begin bad++; $display("FAIL zl_grant got=%b want=10", bus.grant); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL zl_done got=%b want=1", bus.done); end
        total++; if (bus.done_id !== 1'b1) begin bad++; $display("FAIL zl_id got=%0d want=1", bus.done_id); end
        total++; if (bus.done_result !== 256'd0) begin bad++; $display("FAIL zl_result got=%h want=0", bus.done_result); end
        total++; if (bus.done_is_mask !== 1'b0 || bus.done_err !== 1'b0) begin bad++; $display("FAIL zl_flags got=%b%b want=00", bus.done_is_mask, bus.done_err); end
        total++; if (bus.vfu_execute !== 1'b0) begin bad++; $display("FAIL zl_exec got=%b want=0", bus.vfu_execute); end
        bus.req = 2'b00;
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        total++; if (exec_cnt - e0 !== 0) begin bad++; $display("FAIL zl_exec_count got=%0d want=0", exec_cnt - e0); end
    endtask

    task automatic test_timeout();
        int lat;
        work_cycles = -1;
        bus.req_length = {4'd0, 4'd3};
        bus.req = 2'b01;
        tick();
        total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL to_grant got=%b want=01", bus.grant); end
        bus.req = 2'b00;
        wait_done(lat);
        total++; if (lat !== 65) begin bad++; $display("FAIL to_latency got=%0d want=65", lat); end
        total++; if (bus.done_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", bus.done_err); end
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", bus.timeout_err); end
        total++; if (bus.done_result !== 256'd0) begin bad++; $display("FAIL to_result got=%h want=0", bus.done_result); end
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        tick();
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky_after_ack got=%b want=1", bus.timeout_err); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL to_done_drop got=%b want=0", bus.done); end
    endtask

    task automatic test_rdy_freeze();
        int lat;
        int e0;
        e0 = exec_cnt;
        work_cycles = 2;
        bus.req_length = {4'd0, 4'd4};
        bus.req = 2'b01;
        tick();
        rdy_in = 1'b0;
        #1;
        total++; if (bus.vfu_execute !== 1'b0) begin bad++; $display("FAIL fz_exec_low got=%b want=0", bus.vfu_execute); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.vfu_execute !== 1'b0 || bus.grant !== 2'b01 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL fz_issue%0d exec=%b grant=%b busy=%b want 0/01/1", i, bus.vfu_execute, bus.grant, bus.busy);
            end
        end
        rdy_in = 1'b1;
        #1;
        total++; if (bus.vfu_execute !== 1'b1) begin bad++; $display("FAIL fz_exec_resume got=%b want=1", bus.vfu_execute); end
        bus.req = 2'b00;
        wait_done(lat);
        total++; if (lat < 0 || exec_cnt - e0 !== 1) begin bad++; $display("FAIL fz_exec_count got=%0d want=1 lat=%0d", exec_cnt - e0, lat); end
        rdy_in = 1'b0;
        bus.done_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.done !== 1'b1 || bus.done_id !== 1'b0 || bus.done_result !== RES_PAT) begin
                bad++; $display("FAIL fz_resp%0d done=%b id=%0d want 1/0", i, bus.done, bus.done_id);
            end
        end
        rdy_in = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL fz_ack_release got=%b want=0", bus.done); end
    endtask

    task automatic test_reset_in_wait();
        int lat;
        work_cycles = -1;
        bus.req_length = {4'd4, 4'd4};
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rw_busy_before got=%b want=1", bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.grant !== 2'b00) begin
            bad++; $display("FAIL rw_cleared busy=%b done=%b grant=%b want 0/0/00", bus.busy, bus.done, bus.grant);
        end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rw_terr_cleared got=%b want=0", bus.timeout_err); end
        work_cycles = 1;
        bus.req = 2'b11;
        tick();
        total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL rw_rr_ptr_zero got=%b want=01", bus.grant); end
        bus.req = 2'b00;
        wait_done(lat);
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
        bus.req = 2'b10;
        tick();
        total++; if (bus.grant !== 2'b10 || bus.vfu_payload !== PAY1) begin
            bad++; $display("FAIL rw_req1 grant=%b pay=%h want 10/%h", bus.grant, bus.vfu_payload, PAY1);
        end
        bus.req = 2'b00;
        wait_done(lat);
        total++; if (lat < 0 || bus.done_id !== 1'b1 || bus.done_result !== RES_PAT) begin
            bad++; $display("FAIL rw_req1_done id=%0d lat=%0d want id=1", bus.done_id, lat);
        end
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        rdy_in          = 1'b1;
        bus.req         = 2'b00;
        bus.req_payload = {PAY1, PAY0};
        bus.req_length  = '0;
        bus.vfu_result  = RES_PAT;
        bus.vfu_is_mask = 1'b1;
        bus.done_ack    = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_zero_length();
        test_timeout();
        test_rdy_freeze();
        test_reset_in_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_issue_scheduler.md
Name: vector_issue_scheduler

Overview:
- Shares one vector function unit (VFU) between NUM_REQ requesters, e.g. the decode/issue path and the vector LSU retry path.
- Picks one request by round-robin, issues it to the VFU with a single-cycle execute pulse, and waits for the VFU FINISHED status.
- Captures the VFU result and returns it to the winning requester through a held done/ack handshake.
- Only one instruction is in flight at a time.

Parameters:
- NUM_REQ, 2: number of requesters.
- REQ_INDEX_SIZE, 1: width of requester id; log2(NUM_REQ).
- PAYLOAD_WIDTH, 48: opaque per-request VFU control bundle (funct6, VSEW, vm, operand type, alu signal, ext type, imm/rs selects). Passed through unmodified.
- ENTRY_INDEX_SIZE, 3: vector length field is ENTRY_INDEX_SIZE+1 bits.
- RESULT_WIDTH, 256: VFU result width.
- TIMEOUT_CYCLES, 64: maximum active cycles spent waiting for FINISHED.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when low the block is frozen
- req  in  NUM_REQ  per-requester request, held until grant
- req_payload  in  NUM_REQ*PAYLOAD_WIDTH  control bundle; requester i occupies slice [(i+1)*PAYLOAD_WIDTH-1 -: PAYLOAD_WIDTH]
- req_length  in  NUM_REQ*(ENTRY_INDEX_SIZE+1)  vector length per requester, same slicing
- grant  out  NUM_REQ  one-hot acceptance pulse
- vfu_execute  out  1  execute strobe to the VFU
- vfu_payload  out  PAYLOAD_WIDTH  latched bundle of the winner
- vfu_length  out  ENTRY_INDEX_SIZE+1  latched length of the winner
- vfu_status  in  2  VFU status: 00 NOP, 01 WORKING, 10 FINISHED
- vfu_result  in  RESULT_WIDTH  VFU result bus
- vfu_is_mask  in  1  VFU mask-result flag
- done  out  1  response valid, held until done_ack
- done_id  out  REQ_INDEX_SIZE  requester the response belongs to
- done_result  out  RESULT_WIDTH  captured result
- done_is_mask  out  1  captured mask flag
- done_err  out  1  response terminated by timeout
- done_ack  in  1  consumer accepts the response
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Reset (rst high at a clk edge, in any state): state goes to IDLE; rr_ptr=0; wait counter=0. Every output register is cleared: grant, done, done_id, done_result, done_is_mask, done_err, timeout_err, vfu_payload, vfu_length. An in-flight instruction is abandoned with no response.
- rdy_in low: state, counters and registered outputs hold. vfu_execute is forced to 0. No request is accepted.
- vfu_execute = (state==ISSUE) && rdy_in, combinational. It is therefore seen by the VFU at exactly one active edge per instruction.
- IDLE, when rdy_in and req != 0:
  - Winner is the first set bit scanning from index rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch the winner's payload, length and id.
  - If length > 0, go to ISSUE.
  - If length == 0, go to RESP with done_result=0, done_is_mask=0, done_err=0. The VFU is never issued, because it ignores zero-length work.
- grant: registered; grant[id]=1 for exactly one cycle, the cycle after acceptance (first ISSUE cycle, or first RESP cycle for length 0). Requesters drop or replace req on grant.
- ISSUE: one active cycle. Clear the wait counter, go to WAIT.
- WAIT: each active cycle, increment the wait counter.
  - If vfu_status==FINISHED: capture vfu_result into done_result and vfu_is_mask into done_is_mask, set done_err=0, go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: set timeout_err (sticky) and done_err=1, done_result=0, go to RESP.
  - FINISHED takes priority when both conditions hold in the same cycle.
- RESP: done=1, and done_id, done_result, done_is_mask, done_err are stable.
  - When done_ack and rdy_in: done goes to 0, rr_ptr = (done_id+1) mod NUM_REQ, go to IDLE.
  - A new request is accepted no earlier than the cycle after done drops.
  - done_ack while done is low is ignored.
- Minimum latency, req sampled to done high: 3 cycles plus VFU compute cycles. VFU compute is ceil(length/LANE_SIZE) cycles with LANE_SIZE=2.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- Requests that change while not granted are re-evaluated each IDLE cycle. No request is queued internally.

Test Plan:
- Single req[0], length=4, VFU model returns FINISHED after 2 WORKING cycles with result 0xA5.. -> exactly one vfu_execute pulse, vfu_length=4, grant=01 one cycle, done=1 with done_id=0 and done_result=0xA5.., held until done_ack.
- req=11 continuously, rr_ptr=0, 4 instructions -> grant order 0,1,0,1; done_id matches; never two executes in flight.
- req[1] with length=0 -> grant=10, done next cycle, done_result=0, vfu_execute never asserted.
- VFU held WORKING forever, TIMEOUT_CYCLES=64 -> done with done_err=1 exactly 64 active WAIT cycles after ISSUE; timeout_err stays 1 after ack until rst.
- rdy_in low for 3 cycles during ISSUE and during RESP -> vfu_execute stays 0 while low, still exactly one execute pulse, outputs frozen, done_ack ignored while rdy_in low.
- rst asserted in WAIT -> next cycle busy=0, done=0, grant=0, rr_ptr=0; a following req[1] is granted normally.
